// File: rtl/int_sched.sv
// ----------------------------------------------------------------------------
// int_sched
//
// Three-channel periodic interrupt-source scheduler for the Z80 interrupt
// controller. It issues one-clock request strobes on int_stbs[2:0]. A shared
// 8-bit prescaler produces a tick. Each channel has a 16-bit reload counter
// that expires once every (period+1) ticks. All registers sit on the Z80
// port bus.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   din[7:0]  write data from the port decoder
//   addr[2:0] register select
//   wr        write strobe, one clk per access
//   dout[7:0] combinational readback of the register at addr
//   int_stbs  registered request strobes, one clk wide per expiry
//
// Register map
//   0/1  ch0 period lo/hi     2/3  ch1 period lo/hi     4/5  ch2 period lo/hi
//   6    prescaler P          7    control {2'b0, oneshot[2:0], run[2:0]}
//
// Period writes
//   A lo write fills a shared shadow byte. The hi write commits {hi, shadow}.
//   A committed period only takes effect at the channel's next reload, so a
//   running channel is never disturbed.
//
// Build option
//   INT_SCHED_ONESHOT_EN : when defined, control bits [5:3] select one-shot
//   mode per channel. A one-shot channel drops its run bit at the edge that
//   issues its strobe. When undefined those bits are absent and read 0.
// ----------------------------------------------------------------------------
module int_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [2:0] addr,
    input  logic       wr,
    output logic [7:0] dout,
    output logic [2:0] int_stbs
);

    logic [2:0][15:0] period;
    logic [2:0][15:0] cnt;
    logic [7:0]       shadow;
    logic [7:0]       presc;
    logic [7:0]       pcnt;
    logic [2:0]       run;
    logic [2:0]       oneshot;

    logic             tick;
    logic             ctrl_wr;
    logic             presc_wr;
    logic [2:0]       commit;
    logic [2:0][15:0] period_nxt;
    logic [2:0]       start;
    logic [2:0]       stop;
    logic [2:0]       expire;
    logic [2:0]       strobe_nxt;
    logic [2:0]       oneshot_hit;
    logic [2:0]       run_nxt;
    logic [2:0][15:0] cnt_nxt;
    logic [7:0]       pcnt_nxt;

    // Next value of a running channel counter on a tick. An expired
    // counter reloads instead of decrementing, so it never wraps.
    function automatic logic [15:0] count_step(input logic [15:0] cur,
                                               input logic [15:0] reload);
        if (cur == 16'd0) begin
            return reload;
        end
        return cur - 16'd1;
    endfunction

    assign tick     = (pcnt == 8'd0);
    assign ctrl_wr  = wr && (addr == 3'd7);
    assign presc_wr = wr && (addr == 3'd6);

    always_comb begin
        commit      = '0;
        period_nxt  = period;
        start       = '0;
        stop        = '0;
        expire      = '0;
        strobe_nxt  = '0;
        cnt_nxt     = cnt;
        for (int i = 0; i < 3; i++) begin
            commit[i] = wr && (addr == 3'(2 * i + 1));
            // A commit in the same cycle as a reload must feed the reload.
            if (commit[i]) begin
                period_nxt[i] = {din, shadow};
            end
            start[i]      = ctrl_wr && din[i] && !run[i];
            stop[i]       = ctrl_wr && !din[i];
            expire[i]     = tick && run[i] && (cnt[i] == 16'd0);
            // A control write clearing run beats a coincident expiry.
            strobe_nxt[i] = expire[i] && !stop[i];
            if (start[i]) begin
                cnt_nxt[i] = period_nxt[i];
            end else if (stop[i]) begin
                cnt_nxt[i] = cnt[i];
            end else if (run[i] && tick) begin
                cnt_nxt[i] = count_step(cnt[i], period_nxt[i]);
            end
        end
    end

`ifdef INT_SCHED_ONESHOT_EN
    assign oneshot_hit = strobe_nxt & oneshot;
`else
    assign oneshot_hit = 3'b000;
`endif

    assign run_nxt  = (ctrl_wr ? din[2:0] : run) & ~oneshot_hit;

    // Writing P also reloads the prescaler counter immediately.
    assign pcnt_nxt = presc_wr ? din :
                      tick     ? presc :
                                 pcnt - 8'd1;

    // Register stage: configuration, counters and the strobe register.
    always_ff @(posedge clk) begin
        if (rst) begin
            period   <= '0;
            cnt      <= '0;
            shadow   <= '0;
            presc    <= '0;
            pcnt     <= '0;
            run      <= '0;
            int_stbs <= '0;
        end else begin
            if (wr && (addr == 3'd0 || addr == 3'd2 || addr == 3'd4)) begin
                shadow <= din;
            end
            if (presc_wr) begin
                presc <= din;
            end
            period   <= period_nxt;
            cnt      <= cnt_nxt;
            pcnt     <= pcnt_nxt;
            run      <= run_nxt;
            int_stbs <= strobe_nxt;
        end
    end

`ifdef INT_SCHED_ONESHOT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oneshot <= '0;
        end else if (ctrl_wr) begin
            oneshot <= din[5:3];
        end
    end
`else
    assign oneshot = 3'b000;
`endif

    // Readback returns committed periods, never the shadow byte.
    always_comb begin
        dout = 8'h00;
        case (addr)
            3'd0: dout = period[0][7:0];
            3'd1: dout = period[0][15:8];
            3'd2: dout = period[1][7:0];
            3'd3: dout = period[1][15:8];
            3'd4: dout = period[2][7:0];
            3'd5: dout = period[2][15:8];
            3'd6: dout = presc;
            3'd7: dout = {2'b00, oneshot, run};
            default: dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_int_sched.sv
// ----------------------------------------------------------------------------
// tb_int_sched
//
// Directed bench for int_sched. A behavioural model of the register map,
// prescaler and channel timing runs alongside the DUT. The outputs int_stbs
// and dout are compared against it on every cycle. Hand-computed pulse
// timings and readback values pin the model for each scenario.
// ----------------------------------------------------------------------------
module tb_int_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic [2:0] addr = 3'd0;
    logic       wr = 1'b0;
    logic [7:0] dout;
    logic [2:0] int_stbs;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit en_cmp = 1'b0;
    int last_wr_cyc = 0;

    int q0[$];
    int q1[$];
    int q2[$];

    // Model state
    logic [15:0] m_per [3];
    logic [15:0] m_cnt [3];
    logic [7:0]  m_sh;
    logic [7:0]  m_P;
    logic [7:0]  m_pcnt;
    logic [2:0]  m_run;
    logic [2:0]  m_os;
    logic [2:0]  exp_stb;

    int_sched dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .addr     (addr),
        .wr       (wr),
        .dout     (dout),
        .int_stbs (int_stbs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mread(input logic [2:0] a);
        case (a)
            3'd0: return int'(m_per[0][7:0]);
            3'd1: return int'(m_per[0][15:8]);
            3'd2: return int'(m_per[1][7:0]);
            3'd3: return int'(m_per[1][15:8]);
            3'd4: return int'(m_per[2][7:0]);
            3'd5: return int'(m_per[2][15:8]);
            3'd6: return int'(m_P);
            default: return int'({2'b00, m_os, m_run});
        endcase
    endfunction

    // One clock of the scheduler's behaviour, from the register-level rules:
    // period commits land first so a same-edge reload sees them, then ticks
    // age the running channels, then a control write starts or stops them.
    task automatic model_step();
        logic       tk;
        logic [2:0] fire;
        logic [2:0] os_old;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_per[i] = 16'h0;
                m_cnt[i] = 16'h0;
            end
            m_sh = 8'h0; m_P = 8'h0; m_pcnt = 8'h0;
            m_run = 3'b0; m_os = 3'b0; exp_stb = 3'b0;
            return;
        end
        tk = (m_pcnt == 8'h0);
        fire = 3'b0;
        os_old = m_os;
        if (wr) begin
            if (addr == 3'd0 || addr == 3'd2 || addr == 3'd4) m_sh = din;
            if (addr == 3'd1 || addr == 3'd3 || addr == 3'd5)
                m_per[int'(addr) / 2] = {din, m_sh};
        end
        for (int i = 0; i < 3; i++) begin
            if (m_run[i] && tk) begin
                if (m_cnt[i] == 16'h0) begin
                    fire[i] = 1'b1;
                    m_cnt[i] = m_per[i];
                end else begin
                    m_cnt[i] = m_cnt[i] - 16'h1;
                end
            end
        end
        if (wr && addr == 3'd7) begin
            for (int i = 0; i < 3; i++) begin
                if (din[i] && !m_run[i]) m_cnt[i] = m_per[i];
                if (!din[i]) fire[i] = 1'b0;
            end
            m_run = din[2:0];
`ifdef INT_SCHED_ONESHOT_EN
            m_os = din[5:3];
`endif
        end
`ifdef INT_SCHED_ONESHOT_EN
        m_run = m_run & ~(fire & os_old);
`endif
        if (wr && addr == 3'd6) begin
            m_P = din;
            m_pcnt = din;
        end else if (tk) begin
            m_pcnt = m_P;
        end else begin
            m_pcnt = m_pcnt - 8'h1;
        end
        exp_stb = fire;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Compare process and pulse recorder, both away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (en_cmp) begin
                chk("int_stbs", int'(int_stbs), int'(exp_stb));
                chk("dout", int'(dout), mread(addr));
            end
            if (int_stbs[0] === 1'b1) q0.push_back(cyc);
            if (int_stbs[1] === 1'b1) q1.push_back(cyc);
            if (int_stbs[2] === 1'b1) q2.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk);
        #2;
        wr = 1'b1; addr = a; din = d;
        @(posedge clk);
        #1 last_wr_cyc = cyc;
        #1 wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input int exp);
        @(posedge clk);
        #2 addr = a;
        #1 chk(name, int'(dout), exp);
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q2.delete();
    endtask

    int s;

    initial begin
        // Reset: hold for two clocks, then every register reads zero.
        @(posedge clk);
        #1 en_cmp = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 8; a++) rd_chk("reset_read", 3'(a), 0);
        clear_q();
        idle(100);
        chk("reset_quiet_pulses", q0.size() + q1.size() + q2.size(), 0);

        // Basic period: P=0, ch0 period 3 -> pulses 4, 8, 12 clk after start.
        wr_reg(3'd6, 8'h00);
        wr_reg(3'd0, 8'h03);
        wr_reg(3'd1, 8'h00);
        clear_q();
        wr_reg(3'd7, 8'h01);
        s = last_wr_cyc;
        idle(13);
        chk("basic_count", (q0.size() >= 3) ? 1 : 0, 1);
        if (q0.size() >= 3) begin
            chk("basic_first", q0[0] - s, 4);
            chk("basic_second", q0[1] - s, 8);
            chk("basic_third", q0[2] - s, 12);
        end
        chk("basic_other_ch", q1.size() + q2.size(), 0);
        wr_reg(3'd7, 8'h00);

        // Prescaler: P=2, ch1 period 1 -> interval (1+1)*(2+1) = 6.
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd6, 8'h02);
        clear_q();
        wr_reg(3'd7, 8'h02);
        idle(30);
        chk("presc_count", (q1.size() >= 3) ? 1 : 0, 1);
        if (q1.size() >= 3) begin
            chk("presc_interval_a", q1[1] - q1[0], 6);
            chk("presc_interval_b", q1[2] - q1[1], 6);
        end
        wr_reg(3'd7, 8'h00);
        wr_reg(3'd6, 8'h00);

        // Shadow commit: ch2 period 5, lo-only write leaves it at 5.
        wr_reg(3'd4, 8'h05);
        wr_reg(3'd5, 8'h00);
        wr_reg(3'd7, 8'h04);
        idle(8);
        wr_reg(3'd4, 8'h09);
        rd_chk("shadow_lo_only_read", 3'd4, 8'h05);
        clear_q();
        idle(14);
        chk("shadow_keep_count", (q2.size() >= 2) ? 1 : 0, 1);
        if (q2.size() >= 2) chk("shadow_keep_interval", q2[1] - q2[0], 6);
        wr_reg(3'd5, 8'h00);
        rd_chk("shadow_commit_read", 3'd4, 8'h09);
        clear_q();
        idle(40);
        chk("shadow_new_count", (q2.size() >= 3) ? 1 : 0, 1);
        if (q2.size() >= 3) chk("shadow_new_interval", q2[q2.size()-1] - q2[q2.size()-2], 10);
        wr_reg(3'd7, 8'h00);

        // Stop race: control 0x00 sampled on the edge ch0 expires.
        clear_q();
        wr_reg(3'd7, 8'h01);
        idle(2);
        wr_reg(3'd7, 8'h00);
        idle(10);
        chk("stop_race_pulses", q0.size(), 0);
        rd_chk("stop_race_ctrl", 3'd7, 8'h00);

        // Reset mid-count, on the edge ch0 would expire.
        clear_q();
        wr_reg(3'd7, 8'h01);
        idle(2);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        idle(10);
        chk("mid_reset_pulses", q0.size(), 0);
        rd_chk("mid_reset_period", 3'd0, 8'h00);
        rd_chk("mid_reset_ctrl", 3'd7, 8'h00);

        // One-shot request: control 0x09, ch0 period 2, P=0.
        wr_reg(3'd0, 8'h02);
        wr_reg(3'd1, 8'h00);
        clear_q();
        wr_reg(3'd7, 8'h09);
        s = last_wr_cyc;
        idle(15);
        chk("oneshot_has_pulse", (q0.size() >= 1) ? 1 : 0, 1);
        if (q0.size() >= 1) chk("oneshot_first", q0[0] - s, 3);
`ifdef INT_SCHED_ONESHOT_EN
        chk("oneshot_count", q0.size(), 1);
        rd_chk("oneshot_ctrl", 3'd7, 8'h08);
`else
        chk("periodic_count", (q0.size() >= 3) ? 1 : 0, 1);
        if (q0.size() >= 2) chk("periodic_interval", q0[1] - q0[0], 3);
        rd_chk("periodic_ctrl", 3'd7, 8'h01);
`endif
        wr_reg(3'd7, 8'h00);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
